// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: serial-to-byte deserializer with COM-symbol alignment and lock (clk_32f domain).
// Latency: a byte is presented on data_out/valid_out at the same edge that samples its last bit.
// Backpressure: none; the lane runs at line rate and the downstream stage must accept every strobe.
// Optional build macro COM_PASS_EN: forward COM bytes in ACTIVE with valid_out=1 instead of dropping them.
module serial_paralelo_rx #(
  parameter logic [7:0] COM     = 8'hBC,
  parameter int         BC_LOCK = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGN    = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  // Lock threshold in the width of bc_cnt; legal BC_LOCK values 1..7 fit.
  localparam logic [2:0] LOCK_N = 3'(BC_LOCK);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] sr;
  logic [7:0] nsr;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_nxt;
  logic [2:0] bc_cnt;
  logic [2:0] bc_cnt_nxt;
  logic [2:0] bc_inc;
  logic [7:0] data_out_nxt;
  logic       valid_nxt;
  logic       is_com;
  logic       byte_end;

  // Window including the bit arriving this cycle; every decision looks at it.
  assign nsr      = {sr[6:0], data_in};
  assign is_com   = (nsr == COM);
  assign byte_end = (bit_cnt == 3'd7);
  assign bc_inc   = bc_cnt + 3'd1;
  assign active   = (state == ACTIVE);

  // Next-state, counters and output byte selection.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt + 3'd1;
    bc_cnt_nxt   = bc_cnt;
    data_out_nxt = data_out;
    valid_nxt    = 1'b0;
    unique case (state)
      UNLOCKED: begin
        // Bit-by-bit hunt; the counter only matters once a COM is seen.
        bit_cnt_nxt = bit_cnt;
        if (is_com) begin
          bit_cnt_nxt = 3'd0;
          bc_cnt_nxt  = 3'd1;
          state_nxt   = (BC_LOCK == 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (byte_end) begin
          if (is_com) begin
            bc_cnt_nxt = bc_inc;
            if (bc_inc == LOCK_N) begin
              state_nxt = ACTIVE;
            end
          end else begin
            // Broken run: resume hunting from the next bit, no re-scan.
            bc_cnt_nxt = 3'd0;
            state_nxt  = UNLOCKED;
          end
        end
      end
      ACTIVE: begin
        // No loss-of-lock detection: only reset leaves this state.
        if (byte_end) begin
          data_out_nxt = nsr;
`ifdef COM_PASS_EN
          valid_nxt    = 1'b1;
`else
          valid_nxt    = !is_com;
`endif
        end
      end
      default: begin
        state_nxt   = UNLOCKED;
        bit_cnt_nxt = 3'd0;
        bc_cnt_nxt  = 3'd0;
      end
    endcase
  end

  // State, shift register and registered outputs; reset wins over everything.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= UNLOCKED;
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      bc_cnt    <= 3'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= nsr;
      bit_cnt   <= bit_cnt_nxt;
      bc_cnt    <= bc_cnt_nxt;
      data_out  <= data_out_nxt;
      valid_out <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: directed checks of alignment, lock timing, byte strobes and reset.
// Latency: strobes are expected on the edge sampling the last bit of each byte.
// Backpressure: none.
module tb_serial_paralelo_rx;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out0, data_out1;
  logic       valid_out0, valid_out1;
  logic       active0, active1;

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;
  int end_cyc [16];

  // Strobe and active-rise logs per instance
  int         s0_cyc[$];
  logic [7:0] s0_dat[$];
  int         a0_cyc[$];
  int         s1_cyc[$];
  logic [7:0] s1_dat[$];
  int         a1_cyc[$];
  logic       prev_act0 = 1'b0;
  logic       prev_act1 = 1'b0;

  serial_paralelo_rx #(.COM(8'hBC), .BC_LOCK(4)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out0),
    .valid_out (valid_out0),
    .active    (active0)
  );

  serial_paralelo_rx #(.COM(8'hBC), .BC_LOCK(1)) dut1 (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out1),
    .valid_out (valid_out1),
    .active    (active1)
  );

  always #5 clk_32f = ~clk_32f;

  // Edge counter: value after edge k is k
  always @(posedge clk_32f) ecnt <= ecnt + 1;

  // Log strobes and active rises on the falling edge, tagged with the edge that caused them
  always @(negedge clk_32f) begin
    if (valid_out0) begin
      s0_cyc.push_back(ecnt);
      s0_dat.push_back(data_out0);
    end
    if (valid_out1) begin
      s1_cyc.push_back(ecnt);
      s1_dat.push_back(data_out1);
    end
    if (active0 && !prev_act0) a0_cyc.push_back(ecnt);
    if (active1 && !prev_act1) a1_cyc.push_back(ecnt);
    prev_act0 = active0;
    prev_act1 = active1;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data_in = v[i];
      @(posedge clk_32f);
      #1;
    end
  endtask

  task automatic send_byte(input int idx, input logic [7:0] v);
    send_bits(v, 8);
    end_cyc[idx] = ecnt;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (2) begin
      @(posedge clk_32f);
      #1;
    end
    reset = 1'b0;
    chk("reset_active", int'(active0), 0);
    chk("reset_valid", int'(valid_out0), 0);
    chk("reset_data", int'(data_out0), 0);
  endtask

  typedef struct {
    string      name;
    int         npre;
    logic [7:0] pre;
    int         nb;
    logic [7:0] b [10];
    int         act_idx;
    int         nexp;
    logic [7:0] ed [3];
    int         ei [3];
  } vec_t;

  vec_t vecs [4];

  initial begin
    int bs, ba, n;

    vecs[0] = '{"clean", 0, 8'h00, 6,
                '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00},
                3, 2, '{8'h12, 8'h34, 8'h00}, '{4, 5, 0}};
    vecs[1] = '{"misalign", 3, 8'h05, 6,
                '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hFA, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00},
                3, 2, '{8'hFA, 8'h01, 8'h00}, '{4, 5, 0}};
    vecs[2] = '{"broken", 0, 8'h00, 9,
                '{8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hAA, 8'h00},
                7, 1, '{8'hAA, 8'h00, 8'h00}, '{8, 0, 0}};
`ifdef COM_PASS_EN
    vecs[3] = '{"idle", 0, 8'h00, 7,
                '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h12, 8'hBC, 8'h34, 8'h00, 8'h00, 8'h00},
                3, 3, '{8'h12, 8'hBC, 8'h34}, '{4, 5, 6}};
`else
    vecs[3] = '{"idle", 0, 8'h00, 7,
                '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h12, 8'hBC, 8'h34, 8'h00, 8'h00, 8'h00},
                3, 2, '{8'h12, 8'h34, 8'h00}, '{4, 6, 0}};
`endif

    // Table-driven scenarios on the BC_LOCK=4 instance
    for (int v = 0; v < 4; v++) begin
      do_reset();
      bs = s0_cyc.size();
      ba = a0_cyc.size();
      if (vecs[v].npre > 0) send_bits(vecs[v].pre, vecs[v].npre);
      for (int i = 0; i < vecs[v].nb; i++) send_byte(i, vecs[v].b[i]);
      @(negedge clk_32f);
      #1;
      n = s0_cyc.size() - bs;
      chk({vecs[v].name, "_nstrobe"}, n, vecs[v].nexp);
      for (int j = 0; j < vecs[v].nexp; j++) begin
        if (j < n) begin
          chk({vecs[v].name, "_data"}, int'(s0_dat[bs + j]), int'(vecs[v].ed[j]));
          chk({vecs[v].name, "_strobe_edge"}, s0_cyc[bs + j], end_cyc[vecs[v].ei[j]]);
        end
      end
      chk({vecs[v].name, "_nrise"}, a0_cyc.size() - ba, 1);
      if (a0_cyc.size() > ba)
        chk({vecs[v].name, "_rise_edge"}, a0_cyc[ba], end_cyc[vecs[v].act_idx]);
      if (v == 0 && a0_cyc.size() > ba)
        chk("clean_rise_after_first_bc", a0_cyc[ba] - end_cyc[0], 24);
    end

    // Reset in the middle of byte 0x56 while ACTIVE
    do_reset();
    bs = s0_cyc.size();
    for (int i = 0; i < 4; i++) send_byte(i, 8'hBC);
    send_byte(4, 8'h12);
    send_bits(8'h05, 4);
    chk("midrst_pre_active", int'(active0), 1);
    chk("midrst_pre_nstrobe", s0_cyc.size() - bs, 1);
    reset   = 1'b1;
    data_in = 1'b0;
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
    chk("midrst_active", int'(active0), 0);
    chk("midrst_valid", int'(valid_out0), 0);
    chk("midrst_data", int'(data_out0), 0);
    bs = s0_cyc.size();
    ba = a0_cyc.size();
    send_bits(8'h06, 4);
    send_byte(0, 8'h78);
    @(negedge clk_32f);
    #1;
    chk("midrst_no_strobe", s0_cyc.size() - bs, 0);
    chk("midrst_no_active", int'(active0), 0);
    for (int i = 0; i < 4; i++) send_byte(i, 8'hBC);
    send_byte(4, 8'h78);
    @(negedge clk_32f);
    #1;
    chk("relock_nrise", a0_cyc.size() - ba, 1);
    if (a0_cyc.size() > ba) chk("relock_rise_edge", a0_cyc[ba], end_cyc[3]);
    n = s0_cyc.size() - bs;
    chk("relock_nstrobe", n, 1);
    if (n > 0) begin
      chk("relock_data", int'(s0_dat[bs]), 8'h78);
      chk("relock_strobe_edge", s0_cyc[bs], end_cyc[4]);
    end

    // BC_LOCK=1 instance: single COM locks, next byte strobes 8 cycles later
    do_reset();
    bs = s1_cyc.size();
    ba = a1_cyc.size();
    send_byte(0, 8'hBC);
    send_byte(1, 8'h99);
    @(negedge clk_32f);
    #1;
    chk("lock1_nrise", a1_cyc.size() - ba, 1);
    if (a1_cyc.size() > ba) chk("lock1_rise_edge", a1_cyc[ba], end_cyc[0]);
    n = s1_cyc.size() - bs;
    chk("lock1_nstrobe", n, 1);
    if (n > 0) begin
      chk("lock1_data", int'(s1_dat[bs]), 8'h99);
      chk("lock1_strobe_gap", s1_cyc[bs] - a1_cyc[ba], 8);
    end
    chk("lock4_not_active", int'(active0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
